// File: rtl/fifo_pkg.sv
// Shared constants for the 32x6 RAM-backed FIFO controller.
// DEPTH/WIDTH describe the RAM primitive; pointer and count widths derive
// from them. Count width covers 0..DEPTH+1 (RAM words plus output register).
package fifo_pkg;

  localparam int DEPTH           = 32;
  localparam int WIDTH           = 6;
  localparam int PTR_W           = $clog2(DEPTH);
  localparam int CNT_W           = $clog2(DEPTH + 2);
  localparam int AFULL_LVL_DEF   = 28;
  localparam int AEMPTY_LVL_DEF  = 4;

  // Pointer advance; wraps naturally because DEPTH is a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/RAM32X6SDP.sv
// 32x6 simple-dual-port RAM: synchronous write, asynchronous read.
// Ports:
//   WCLK  - write clock
//   WE    - write enable
//   WADDR - write address
//   DI    - write data
//   RADDR - read address
//   DO    - read data (combinational from RADDR)
module RAM32X6SDP
  import fifo_pkg::*;
(
  input  logic             WCLK,
  input  logic             WE,
  input  logic [PTR_W-1:0] WADDR,
  input  logic [WIDTH-1:0] DI,
  input  logic [PTR_W-1:0] RADDR,
  output logic [WIDTH-1:0] DO
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge WCLK) begin
    if (WE) begin
      mem[WADDR] <= DI;
    end
  end

  assign DO = mem[RADDR];

endmodule

// File: rtl/ram32x6_fifo_ctrl.sv
// FIFO controller around a 32x6 SDP RAM plus one registered output word,
// giving a total capacity of 33 words.
// Ports:
//   CLK      - single clock (also the RAM write clock)
//   RST_N    - synchronous active-low reset
//   DI       - write data;  DI_VALID / DI_READY handshake
//   DO       - registered head-of-queue data; DO_VALID / DO_READY handshake
//   FLUSH    - synchronous queue clear (DO data is left as is)
//   COUNT    - words held (RAM occupancy + output register)
//   AFULL    - COUNT >= AFULL_LVL
//   AEMPTY   - COUNT <= AEMPTY_LVL
module ram32x6_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int AFULL_LVL  = AFULL_LVL_DEF,
  parameter int AEMPTY_LVL = AEMPTY_LVL_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DI,
  input  logic             DI_VALID,
  output logic             DI_READY,
  output logic [WIDTH-1:0] DO,
  output logic             DO_VALID,
  input  logic             DO_READY,
  input  logic             FLUSH,
  output logic [CNT_W-1:0] COUNT,
  output logic             AFULL,
  output logic             AEMPTY
);

  logic [PTR_W-1:0] wptr_reg, wptr_next;
  logic [PTR_W-1:0] rptr_reg, rptr_next;
  logic [CNT_W-1:0] rcnt_reg, rcnt_next;
  logic [WIDTH-1:0] do_reg, do_next;
  logic             do_valid_reg, do_valid_next;
  logic [WIDTH-1:0] ram_rdata;
  logic             wr_en;
  logic             ld_en;
  logic             ram_we;

  // Ready depends only on registered occupancy (and reset), never on the
  // consumer side, so a load at RCNT=32 only frees a slot for the next cycle.
  assign DI_READY = RST_N && (rcnt_reg != CNT_W'(DEPTH));
  assign wr_en    = DI_VALID && DI_READY;
  assign ld_en    = (rcnt_reg != '0) && (!do_valid_reg || DO_READY);
  // A flushed write must not land in the RAM either; it is simply dropped.
  assign ram_we   = wr_en && !FLUSH;

  RAM32X6SDP u_ram (
    .WCLK  (CLK),
    .WE    (ram_we),
    .WADDR (wptr_reg),
    .DI    (DI),
    .RADDR (rptr_reg),
    .DO    (ram_rdata)
  );

  always_comb begin
    wptr_next     = wptr_reg;
    rptr_next     = rptr_reg;
    rcnt_next     = rcnt_reg;
    do_next       = do_reg;
    do_valid_next = do_valid_reg;
    if (FLUSH) begin
      wptr_next     = '0;
      rptr_next     = '0;
      rcnt_next     = '0;
      do_valid_next = 1'b0;
    end else begin
      if (wr_en) begin
        wptr_next = ptr_inc(wptr_reg);
      end
      if (ld_en) begin
        do_next       = ram_rdata;
        do_valid_next = 1'b1;
        rptr_next     = ptr_inc(rptr_reg);
      end else if (do_valid_reg && DO_READY) begin
        do_valid_next = 1'b0;
      end
      case ({wr_en, ld_en})
        2'b10:   rcnt_next = rcnt_reg + CNT_W'(1);
        2'b01:   rcnt_next = rcnt_reg - CNT_W'(1);
        default: rcnt_next = rcnt_reg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      rcnt_reg     <= '0;
      do_reg       <= '0;
      do_valid_reg <= 1'b0;
    end else begin
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      rcnt_reg     <= rcnt_next;
      do_reg       <= do_next;
      do_valid_reg <= do_valid_next;
    end
  end

  assign DO       = do_reg;
  assign DO_VALID = do_valid_reg;
  assign COUNT    = rcnt_reg + CNT_W'(do_valid_reg);
  assign AFULL    = (COUNT >= CNT_W'(AFULL_LVL));
  assign AEMPTY   = (COUNT <= CNT_W'(AEMPTY_LVL));

endmodule

// File: tb/tb_ram32x6_fifo_ctrl.sv
// Self-checking bench for ram32x6_fifo_ctrl: a short vector table followed
// by directed multi-cycle sequences (fill/full, wrap, streaming, flush,
// mid-stream reset). Prints one line per check.
module tb_ram32x6_fifo_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [5:0] DI = '0;
  logic       DI_VALID = 1'b0;
  logic       DI_READY;
  logic [5:0] DO;
  logic       DO_VALID;
  logic       DO_READY = 1'b0;
  logic       FLUSH = 1'b0;
  logic [5:0] COUNT;
  logic       AFULL;
  logic       AEMPTY;

  int errors = 0;
  int checks = 0;

  ram32x6_fifo_ctrl dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .DI       (DI),
    .DI_VALID (DI_VALID),
    .DI_READY (DI_READY),
    .DO       (DO),
    .DO_VALID (DO_VALID),
    .DO_READY (DO_READY),
    .FLUSH    (FLUSH),
    .COUNT    (COUNT),
    .AFULL    (AFULL),
    .AEMPTY   (AEMPTY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst_n;
    logic [5:0] di;
    logic       di_valid;
    logic       do_ready;
    logic       flush;
    logic [5:0] e_do;
    logic       e_dv;
    int         e_count;
    logic       e_rdy;
    logic       e_afull;
    logic       e_aempty;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    DI_VALID = 1'b0;
    DO_READY = 1'b0;
    FLUSH    = 1'b0;
  endtask

  initial begin
    //          rst  di     vld   rdy   fl    do     dv   cnt rdy  af   ae
    vecs[0] = '{1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 0, 1'b0, 1'b0, 1'b1}; // reset
    vecs[1] = '{1'b1, 6'h15, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 1, 1'b1, 1'b0, 1'b1}; // write 15
    vecs[2] = '{1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 6'h15, 1'b1, 1, 1'b1, 1'b0, 1'b1}; // load 15
    vecs[3] = '{1'b1, 6'h2A, 1'b1, 1'b0, 1'b0, 6'h15, 1'b1, 2, 1'b1, 1'b0, 1'b1}; // write, hold DO
    vecs[4] = '{1'b1, 6'h07, 1'b1, 1'b1, 1'b0, 6'h2A, 1'b1, 2, 1'b1, 1'b0, 1'b1}; // write+load
    vecs[5] = '{1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 6'h07, 1'b1, 1, 1'b1, 1'b0, 1'b1}; // load last
    vecs[6] = '{1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 6'h07, 1'b0, 0, 1'b1, 1'b0, 1'b1}; // pop only
    vecs[7] = '{1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 6'h07, 1'b0, 0, 1'b1, 1'b0, 1'b1}; // idle
    vecs[8] = '{1'b1, 6'h11, 1'b1, 1'b0, 1'b1, 6'h07, 1'b0, 0, 1'b1, 1'b0, 1'b1}; // flush+write
    vecs[9] = '{1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 6'h07, 1'b0, 0, 1'b1, 1'b0, 1'b1}; // word lost

    for (int i = 0; i < 10; i++) begin
      RST_N    = vecs[i].rst_n;
      DI       = vecs[i].di;
      DI_VALID = vecs[i].di_valid;
      DO_READY = vecs[i].do_ready;
      FLUSH    = vecs[i].flush;
      tick();
      check($sformatf("vec%0d DO", i),       int'(DO),       int'(vecs[i].e_do));
      check($sformatf("vec%0d DO_VALID", i), int'(DO_VALID), int'(vecs[i].e_dv));
      check($sformatf("vec%0d COUNT", i),    int'(COUNT),    vecs[i].e_count);
      check($sformatf("vec%0d DI_READY", i), int'(DI_READY), int'(vecs[i].e_rdy));
      check($sformatf("vec%0d AFULL", i),    int'(AFULL),    int'(vecs[i].e_afull));
      check($sformatf("vec%0d AEMPTY", i),   int'(AEMPTY),   int'(vecs[i].e_aempty));
    end
    idle_inputs();

    // Fill: write 0..32 with the consumer stalled.
    for (int n = 1; n <= 33; n++) begin
      DI = 6'(n - 1);
      DI_VALID = 1'b1;
      tick();
      check($sformatf("fill%0d COUNT", n),    int'(COUNT),    n);
      check($sformatf("fill%0d AFULL", n),    int'(AFULL),    (n >= 28) ? 1 : 0);
      check($sformatf("fill%0d AEMPTY", n),   int'(AEMPTY),   (n <= 4) ? 1 : 0);
      check($sformatf("fill%0d DI_READY", n), int'(DI_READY), (n < 33) ? 1 : 0);
    end
    // 34th word must be ignored.
    DI = 6'h3E;
    tick();
    check("full ignore COUNT", int'(COUNT), 33);
    check("full DI_READY", int'(DI_READY), 0);
    check("full DO", int'(DO), 0);

    // One pop from full: ready stays low in that cycle, rises after.
    DI_VALID = 1'b0;
    DO_READY = 1'b1;
    #1;
    check("pop cycle DI_READY", int'(DI_READY), 0);
    tick();
    check("after pop DO", int'(DO), 1);
    check("after pop DI_READY", int'(DI_READY), 1);
    check("after pop COUNT", int'(COUNT), 32);
    DO_READY = 1'b0;
    DI = 6'h3F;
    DI_VALID = 1'b1;
    tick();
    check("wrap write COUNT", int'(COUNT), 33);
    DI_VALID = 1'b0;

    // Drain: expect 2..32 then 3F.
    DO_READY = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check($sformatf("drain%0d DO", i), int'(DO), (i < 31) ? (i + 2) : 63);
    end
    check("drain tail COUNT", int'(COUNT), 1);
    tick();
    check("drain empty COUNT", int'(COUNT), 0);
    check("drain empty DO_VALID", int'(DO_VALID), 0);

    // Streaming at full rate.
    DI_VALID = 1'b1;
    DO_READY = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      DI = 6'(n - 1);
      tick();
      if (n == 1) begin
        check("stream1 COUNT", int'(COUNT), 1);
      end else begin
        check($sformatf("stream%0d DO", n),       int'(DO),       (n - 2) & 63);
        check($sformatf("stream%0d DO_VALID", n), int'(DO_VALID), 1);
        check($sformatf("stream%0d COUNT", n),    int'(COUNT),    2);
      end
    end
    DI_VALID = 1'b0;
    tick();
    check("stream tail DO", int'(DO), 99 & 63);
    check("stream tail COUNT", int'(COUNT), 1);
    tick();
    check("stream empty COUNT", int'(COUNT), 0);
    idle_inputs();

    // Flush at COUNT=10 together with a write.
    for (int n = 0; n < 10; n++) begin
      DI = 6'(n + 16);
      DI_VALID = 1'b1;
      tick();
    end
    check("preflush COUNT", int'(COUNT), 10);
    DI = 6'h3A;
    FLUSH = 1'b1;
    tick();
    check("flush COUNT", int'(COUNT), 0);
    check("flush DO_VALID", int'(DO_VALID), 0);
    check("flush DO held", int'(DO), 16);
    idle_inputs();
    tick();
    tick();
    check("postflush COUNT", int'(COUNT), 0);
    check("postflush DO_VALID", int'(DO_VALID), 0);

    // Reset mid-stream at COUNT=20.
    for (int n = 0; n < 20; n++) begin
      DI = 6'(n + 40);
      DI_VALID = 1'b1;
      tick();
    end
    check("prereset COUNT", int'(COUNT), 20);
    RST_N = 1'b0;
    DI = 6'h01;
    #1;
    check("in reset DI_READY", int'(DI_READY), 0);
    tick();
    check("reset COUNT", int'(COUNT), 0);
    check("reset DO_VALID", int'(DO_VALID), 0);
    check("reset DO", int'(DO), 0);
    tick();
    check("reset hold COUNT", int'(COUNT), 0);
    check("reset hold DI_READY", int'(DI_READY), 0);
    RST_N = 1'b1;
    DI = 6'h2B;
    tick();
    check("postreset write COUNT", int'(COUNT), 1);
    DI_VALID = 1'b0;
    tick();
    check("postreset DO", int'(DO), 6'h2B);
    check("postreset DO_VALID", int'(DO_VALID), 1);
    check("postreset COUNT", int'(COUNT), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
